muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_pkg.sv | 17 +
 rtl/muldiv_div_iter.sv | 47 ++++
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: FSM states, op and HI/LO select encodings.
package muldiv_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   localparam logic SEL_HI = 1'b0;
   localparam logic SEL_LO = 1'b1;

endpackage

// File: rtl/muldiv_div_iter.sv
// Restoring unsigned divider core: produces one quotient bit per enabled cycle on operand magnitudes.
module muldiv_div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic [WIDTH-1:0] quo_reg, rem_reg, dsr_reg;
   logic [WIDTH:0]   shifted, diff;

   // Partial remainder stays below the divisor, so the shifted value needs only one extra bit.
   always_comb begin
      shifted = {rem_reg, quo_reg[WIDTH-1]};
      diff    = shifted - {1'b0, dsr_reg};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quo_reg <= '0;
         rem_reg <= '0;
         dsr_reg <= '0;
      end else if (load) begin
         quo_reg <= dividend;
         rem_reg <= '0;
         dsr_reg <= divisor;
      end else if (en) begin
         if (!diff[WIDTH]) begin
            rem_reg <= diff[WIDTH-1:0];
            quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
         end else begin
            rem_reg <= shifted[WIDTH-1:0];
            quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign quotient  = quo_reg;
   assign remainder = rem_reg;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers (mthi/mtlo, mfhi/mflo access).
// MULDIV_FAST_MUL_EN: when defined, multiply completes via a single-cycle product instead of shift-add.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic             do_unsigned,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             kill,
   input  logic             wr_en,
   input  logic             wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_sel,
   output logic [WIDTH-1:0] rd_data,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t             state_reg, state_next;
   logic [CW-1:0]      count_reg;
   logic               op_reg, neg_a_reg, neg_b_reg, dz_op_reg, div_by_zero_reg;
   logic [WIDTH-1:0]   a_reg, mag_a_reg, hi_reg, lo_reg;
   logic               accept, neg_a, neg_b, is_dz;
   logic [WIDTH-1:0]   mag_a, mag_b, quo, rem, res_hi, res_lo;
   logic [2*WIDTH-1:0] mul_mag, mul_res;

   assign accept = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
   assign neg_a  = !do_unsigned && src_a[WIDTH-1];
   assign neg_b  = !do_unsigned && src_b[WIDTH-1];
   assign mag_a  = neg_a ? -src_a : src_a;
   assign mag_b  = neg_b ? -src_b : src_b;
   assign is_dz  = (op == OP_DIV) && (src_b == '0);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            state_next = ST_IDLE;
            if (start) begin
               if (is_dz)
                  state_next = ST_FIX;
`ifdef MULDIV_FAST_MUL_EN
               else if (op == OP_MUL)
                  state_next = ST_FIX;
`endif
               else
                  state_next = ST_CALC;
            end
         end
         ST_CALC: begin
            if (kill)
               state_next = ST_IDLE;
            else if (count_reg == LAST)
               state_next = ST_FIX;
         end
         ST_FIX:  state_next = kill ? ST_IDLE : ST_DONE;
         default: state_next = ST_IDLE;
      endcase
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [WIDTH-1:0] mag_b_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         mag_b_reg <= '0;
      else if (accept)
         mag_b_reg <= mag_b;
   end

   assign mul_mag = {{WIDTH{1'b0}}, mag_a_reg} * {{WIDTH{1'b0}}, mag_b_reg};
`else
   // Shift-add: multiplier starts in the low half and is consumed LSB-first as the product shifts in.
   logic [2*WIDTH-1:0] prod_reg;
   logic [WIDTH:0]     mul_sum;

   assign mul_sum = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + (prod_reg[0] ? {1'b0, mag_a_reg} : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         prod_reg <= '0;
      else if (accept)
         prod_reg <= {{WIDTH{1'b0}}, mag_b};
      else if (state_reg == ST_CALC && op_reg == OP_MUL)
         prod_reg <= {mul_sum, prod_reg[WIDTH-1:1]};
   end

   assign mul_mag = prod_reg;
`endif

   muldiv_div_iter #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept),
      .en        (state_reg == ST_CALC && op_reg == OP_DIV),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .quotient  (quo),
      .remainder (rem)
   );

   // Sign fix-up: quotient/product negative on sign mismatch, remainder follows the dividend.
   always_comb begin
      mul_res = (neg_a_reg ^ neg_b_reg) ? -mul_mag : mul_mag;
      res_hi  = mul_res[2*WIDTH-1:WIDTH];
      res_lo  = mul_res[WIDTH-1:0];
      if (op_reg == OP_DIV) begin
         if (dz_op_reg) begin
            res_lo = '1;
            res_hi = a_reg;
         end else begin
            res_lo = (neg_a_reg ^ neg_b_reg) ? -quo : quo;
            res_hi = neg_a_reg ? -rem : rem;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         count_reg       <= '0;
         op_reg          <= OP_MUL;
         neg_a_reg       <= 1'b0;
         neg_b_reg       <= 1'b0;
         dz_op_reg       <= 1'b0;
         a_reg           <= '0;
         mag_a_reg       <= '0;
         hi_reg          <= '0;
         lo_reg          <= '0;
         div_by_zero_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            op_reg          <= op;
            neg_a_reg       <= neg_a;
            neg_b_reg       <= neg_b;
            dz_op_reg       <= is_dz;
            a_reg           <= src_a;
            mag_a_reg       <= mag_a;
            count_reg       <= '0;
            div_by_zero_reg <= 1'b0;
         end else if (state_reg == ST_CALC) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
         end
         if (state_reg == ST_FIX && !kill) begin
            hi_reg          <= res_hi;
            lo_reg          <= res_lo;
            div_by_zero_reg <= dz_op_reg;
         end else if (wr_en && !busy) begin
            if (wr_sel == SEL_LO)
               lo_reg <= wr_data;
            else
               hi_reg <= wr_data;
         end
      end
   end

   assign busy        = (state_reg == ST_CALC) || (state_reg == ST_FIX);
   assign done        = (state_reg == ST_DONE);
   assign div_by_zero = div_by_zero_reg;
   assign rd_data     = (rd_sel == SEL_LO) ? lo_reg : hi_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table, random scoreboard traffic, and hand-written control corner cases.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0, rst_n = 1'b1, start = 1'b0, op = 1'b0, do_unsigned = 1'b0;
   logic         kill = 1'b0, wr_en = 1'b0, wr_sel = 1'b0, rd_sel = 1'b0;
   logic [W-1:0] src_a = '0, src_b = '0, wr_data = '0;
   logic [W-1:0] rd_data;
   logic         busy, done, div_by_zero;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic         op;
      logic         uns;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } vec_t;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           lat;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[16];

   muldiv_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .do_unsigned (do_unsigned),
      .src_a       (src_a),
      .src_b       (src_b),
      .kill        (kill),
      .wr_en       (wr_en),
      .wr_sel      (wr_sel),
      .wr_data     (wr_data),
      .rd_sel      (rd_sel),
      .rd_data     (rd_data),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation ran past its time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
      rd_sel = SEL_HI;
      #1 hi = rd_data;
      rd_sel = SEL_LO;
      #1 lo = rd_data;
   endtask

   task automatic mt(input logic sel, input logic [W-1:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_sel = sel; wr_data = d;
      @(posedge clk);
      #1 wr_en = 1'b0;
   endtask

   // Drive one accepted start and push its expected result; returns 1ns after the accepting edge.
   task automatic issue(input logic o, input logic u, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
      exp_t e;
      @(negedge clk);
      op = o; do_unsigned = u; src_a = a; src_b = b; start = 1'b1;
      e.hi = ehi; e.lo = elo; e.dz = edz;
      e.lat = (o == OP_DIV && b == '0) ? 1 : W + 1;
`ifdef MULDIV_FAST_MUL_EN
      if (o == OP_MUL) e.lat = 1;
`endif
      sb.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
      src_a = ~a; src_b = ~b; op = ~o;
      check("busy_after_start", {63'd0, busy}, 64'd1);
   endtask

   task automatic wait_result(input string name, input int elapsed);
      exp_t         e;
      logic [W-1:0] hi, lo;
      int           k;
      e = sb.pop_front();
      k = 0;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            k = c + elapsed;
            break;
         end
      end
      check({name, "_latency"}, k, e.lat);
      read_hilo(hi, lo);
      $display("txn %s: hi=%h lo=%h dz=%0d done_at=t0+%0d", name, hi, lo, div_by_zero, k + 1);
      check({name, "_hi"}, hi, e.hi);
      check({name, "_lo"}, lo, e.lo);
      check({name, "_dz"}, {63'd0, div_by_zero}, {63'd0, e.dz});
      cycles(1);
      check({name, "_done_one_cycle"}, {63'd0, done}, 64'd0);
   endtask

   initial begin
      logic [W-1:0] hi, lo, a, b, ehi, elo;
      logic         o, u;
      longint       sa, sb_l, q, r;
      logic [63:0]  p;
      int           seen;

      vecs[0]  = '{OP_DIV, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[1]  = '{OP_MUL, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[2]  = '{OP_MUL, 1'b0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
      vecs[3]  = '{OP_DIV, 1'b0, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
      vecs[4]  = '{OP_DIV, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[5]  = '{OP_DIV, 1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
      vecs[6]  = '{OP_MUL, 1'b1, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
      vecs[7]  = '{OP_DIV, 1'b0, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[8]  = '{OP_DIV, 1'b0, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
      vecs[9]  = '{OP_DIV, 1'b1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h7FFFFFFF, 1'b0};
      vecs[10] = '{OP_MUL, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
      vecs[11] = '{OP_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
      vecs[12] = '{OP_MUL, 1'b0, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000, 1'b0};
      vecs[13] = '{OP_DIV, 1'b0, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
      vecs[14] = '{OP_MUL, 1'b0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0};
      vecs[15] = '{OP_DIV, 1'b0, 32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000000, 1'b0};

      // Reset state, asserted asynchronously between clock edges.
      #1 rst_n = 1'b0;
      #11;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_dz", {63'd0, div_by_zero}, 64'd0);
      read_hilo(hi, lo);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         issue(vecs[i].op, vecs[i].uns, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);
         wait_result($sformatf("vec%0d", i), 0);
      end

      // Random traffic against an integer-arithmetic reference.
      for (int i = 0; i < 16; i++) begin
         o = 1'($urandom_range(0, 1));
         u = 1'($urandom_range(0, 1));
         a = $urandom;
         b = $urandom;
         if (i % 4 == 1) b = W'($urandom_range(1, 9));
         if (b == '0) b = 1;
         sa   = u ? longint'({32'd0, a}) : longint'($signed(a));
         sb_l = u ? longint'({32'd0, b}) : longint'($signed(b));
         if (o == OP_MUL) begin
            p   = 64'(sa * sb_l);
            ehi = p[63:32];
            elo = p[31:0];
         end else begin
            q   = sa / sb_l;
            r   = sa % sb_l;
            elo = q[31:0];
            ehi = r[31:0];
         end
         issue(o, u, a, b, ehi, elo, 1'b0);
         wait_result($sformatf("rand%0d", i), 0);
      end

      // Register write coinciding with an accepted start lands, then the result overwrites it.
      @(negedge clk);
      wr_en = 1'b1; wr_sel = SEL_HI; wr_data = 32'h0000DEAD;
      issue(OP_MUL, 1'b1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
      wr_en = 1'b0;
      rd_sel = SEL_HI;
      #1 check("wr_with_start", rd_data, 32'h0000DEAD);
      wait_result("mul_after_wr", 0);

      // Start pulsed while busy must not disturb the running divide.
      issue(OP_DIV, 1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      cycles(1);
      op = OP_MUL; do_unsigned = 1'b1; src_a = 32'd3; src_b = 32'd5; start = 1'b1;
      cycles(1);
      start = 1'b0;
      check("busy_start_still_busy", {63'd0, busy}, 64'd1);
      wait_result("busy_start_ignored", 2);

      // div_by_zero holds through idle cycles and clears on the next accepted start.
      issue(OP_DIV, 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1);
      wait_result("dz_op", 0);
      cycles(3);
      check("dz_hold", {63'd0, div_by_zero}, 64'd1);
      issue(OP_DIV, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      check("dz_clear", {63'd0, div_by_zero}, 64'd0);
      wait_result("div_after_dz", 0);

      // Kill during a divide; a write while busy is dropped.
      mt(SEL_HI, 32'h11111111);
      mt(SEL_LO, 32'h22222222);
      @(negedge clk);
      op = OP_DIV; do_unsigned = 1'b1; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cycles(4);
      wr_en = 1'b1; wr_sel = SEL_HI; wr_data = 32'h00001234;
      cycles(1);
      wr_en = 1'b0;
      cycles(4);
      check("kill_still_busy", {63'd0, busy}, 64'd1);
      kill = 1'b1;
      cycles(1);
      kill = 1'b0;
      check("kill_idle", {63'd0, busy}, 64'd0);
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (done) seen = 1;
         cycles(1);
      end
      check("kill_no_done", seen, 0);
      read_hilo(hi, lo);
      $display("txn kill: hi=%h lo=%h", hi, lo);
      check("kill_hi_kept", hi, 32'h11111111);
      check("kill_lo_kept", lo, 32'h22222222);

      // Asynchronous reset in the middle of a multiply.
      @(negedge clk);
      op = OP_MUL; do_unsigned = 1'b1; src_a = 32'hFFFFFFFF; src_b = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cycles(6);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", {63'd0, busy}, 64'd0);
      check("arst_done", {63'd0, done}, 64'd0);
      read_hilo(hi, lo);
      check("arst_hi", hi, 0);
      check("arst_lo", lo, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (done) seen = 1;
         cycles(1);
      end
      check("arst_no_done", seen, 0);
      mt(SEL_LO, 32'h0000ABCD);
      rd_sel = SEL_LO;
      #1 check("mtlo_after_reset", rd_data, 32'h0000ABCD);
      $display("txn mtlo: lo=%h", rd_data);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
